updown_counter_gen: RTL and testbench

Parametrised up/down counter with a built-in clock-enable prescaler, programmable modulus, synchronous load and a wrap indication. Replaces derived-clock counters: the whole block runs on the single board clock, and the count advances only on prescaler tick cycles. It drives display/LED logic on the Nexys 4 training designs and can be instanced per channel.

---
 rtl/counter_pkg.sv | 11 +
 rtl/tick_gen.sv | 37 +++
 rtl/updown_counter_gen.sv | 91 +++++++++
 tb/tb_updown_counter_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the counter family: step direction encoding and board-level prescaler default.
package counter_pkg;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Nexys 4 runs from a 100 MHz oscillator; this divisor gives a slow visible step.
   localparam int unsigned DEFAULT_DIVISOR = 90_000_000;
   localparam int unsigned DEFAULT_DIV_W   = 28;

endpackage : counter_pkg

// File: rtl/tick_gen.sv
// Clock-enable prescaler: tick_i is high for one enabled cycle every DIVISOR enabled cycles.
module tick_gen
   import counter_pkg::*;
#(
   parameter int unsigned DIVISOR = DEFAULT_DIVISOR,
   parameter int unsigned DIV_W   = DEFAULT_DIV_W
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick_i
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIVISOR - 1);

   logic [DIV_W-1:0] pre_q;
   logic [DIV_W-1:0] pre_d;

   // Combinational so the count steps on the terminal cycle itself.
   assign tick_i = enable && (pre_q == LAST);

   always_comb begin
      pre_d = pre_q;
      if (enable) begin
         pre_d = tick_i ? '0 : pre_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule : tick_gen

// File: rtl/updown_counter_gen.sv
// Prescaled up/down modulo counter with synchronous load and wrap pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module updown_counter_gen
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16,
   parameter int unsigned DIVISOR = DEFAULT_DIVISOR,
   parameter int unsigned DIV_W   = DEFAULT_DIV_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_down_sw,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap
);

   // MODULUS may equal 2**WIDTH, so the top value is always compared explicitly.
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic             tick_c;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tick_q;
   logic             wrap_q;
   logic             wrap_d;

   tick_gen #(
      .DIVISOR (DIVISOR),
      .DIV_W   (DIV_W)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick_i (tick_c)
   );

   // Next count: load beats a coincident step; steps only on prescaler terminal cycles.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = (data > MAX_CNT) ? MAX_CNT : data;
      end else if (tick_c) begin
         if (up_down_sw == DIR_UP) begin
            if (count_q == MAX_CNT) begin
               wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
               count_d = MAX_CNT;
`else
               count_d = '0;
`endif
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
               count_d = '0;
`else
               count_d = MAX_CNT;
`endif
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_c;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;

endmodule : updown_counter_gen

// File: tb/tb_updown_counter_gen.sv
// Bench for updown_counter_gen: stimulus table with hand-derived end counts plus a per-cycle scoreboard.
module tb_updown_counter_gen;

`ifdef UPDOWN_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int MOD_A = 10;
   localparam int DIV_A = 4;
   localparam int MOD_B = 16;
   localparam int MOD_C = 8;
   localparam int DIV_C = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       up_down_sw = 1'b1;
   logic       load = 1'b0;
   logic [3:0] data = 4'd0;

   logic [3:0] count_a, count_b;
   logic [2:0] count_c;
   logic       tick_a, tick_b, tick_c;
   logic       wrap_a, wrap_b, wrap_c;

   always #5 clk = ~clk;

   updown_counter_gen #(.WIDTH(4), .MODULUS(MOD_A), .DIVISOR(DIV_A), .DIV_W(3)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .up_down_sw(up_down_sw),
      .load(load), .data(data), .count(count_a), .tick(tick_a), .wrap(wrap_a));

   updown_counter_gen #(.WIDTH(4), .MODULUS(MOD_B), .DIVISOR(DIV_A), .DIV_W(3)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .up_down_sw(up_down_sw),
      .load(load), .data(data), .count(count_b), .tick(tick_b), .wrap(wrap_b));

   updown_counter_gen #(.WIDTH(3), .MODULUS(MOD_C), .DIVISOR(DIV_C), .DIV_W(1)) dut_c (
      .clk(clk), .reset(reset), .enable(enable), .up_down_sw(up_down_sw),
      .load(load), .data(data[2:0]), .count(count_c), .tick(tick_c), .wrap(wrap_c));

   typedef struct {
      int pre;
      int cnt;
      bit tick;
      bit wrap;
   } mstate_t;

   typedef struct {
      mstate_t a;
      mstate_t b;
      mstate_t c;
   } exp_t;

   typedef struct {
      bit rst;
      bit en;
      bit up;
      bit ld;
      int d;
      int n;
      int ea;
      int eb;
      int sa;
      int sb;
   } vec_t;

   vec_t    vecs[$];
   exp_t    sb[$];
   mstate_t ma, mb, mc;
   int      errors = 0;
   int      checks = 0;
   int      cyc = 0;

   function automatic mstate_t mstep(mstate_t s, int modv, int divv,
                                     bit rst, bit en, bit up, bit ld, int d);
      mstate_t n;
      bit ti;
      n  = s;
      ti = en && (s.pre == divv - 1);
      if (rst) begin
         n.pre = 0; n.cnt = 0; n.tick = 0; n.wrap = 0;
         return n;
      end
      n.tick = ti;
      n.wrap = 0;
      if (en) n.pre = ti ? 0 : s.pre + 1;
      if (ld) begin
         n.cnt = (d > modv - 1) ? modv - 1 : d;
      end else if (ti) begin
         if (up) begin
            if (s.cnt == modv - 1) begin
               n.wrap = 1;
               n.cnt  = SAT ? modv - 1 : 0;
            end else n.cnt = s.cnt + 1;
         end else begin
            if (s.cnt == 0) begin
               n.wrap = 1;
               n.cnt  = SAT ? 0 : modv - 1;
            end else n.cnt = s.cnt - 1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input int gc, input bit gt, input bit gw,
                      input int ec, input bit et, input bit ew);
      checks++;
      if (gc != ec || gt != et || gw != ew) begin
         errors++;
         $display("FAIL %s cyc=%0d got count=%0d tick=%0b wrap=%0b want count=%0d tick=%0b wrap=%0b",
                  name, cyc, gc, gt, gw, ec, et, ew);
      end
   endtask

   task automatic run_cycle(input bit rst, input bit en, input bit up, input bit ld, input int d);
      exp_t e;
      @(negedge clk);
      reset      = rst;
      enable     = en;
      up_down_sw = up;
      load       = ld;
      data       = 4'(d);
      ma = mstep(ma, MOD_A, DIV_A, rst, en, up, ld, d);
      mb = mstep(mb, MOD_B, DIV_A, rst, en, up, ld, d);
      mc = mstep(mc, MOD_C, DIV_C, rst, en, up, ld, d & 7);
      e.a = ma; e.b = mb; e.c = mc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty cyc=%0d got size=0 want size>0", cyc);
      end else begin
         e = sb.pop_front();
         chk("dut_a", int'(count_a), tick_a, wrap_a, e.a.cnt, e.a.tick, e.a.wrap);
         chk("dut_b", int'(count_b), tick_b, wrap_b, e.b.cnt, e.b.tick, e.b.wrap);
         chk("dut_c", int'(count_c), tick_c, wrap_c, e.c.cnt, e.c.tick, e.c.wrap);
      end
   endtask

   initial begin
      ma = '{0, 0, 0, 0}; mb = '{0, 0, 0, 0}; mc = '{0, 0, 0, 0};
      //              rst en up ld  d  n  ea eb  sa sb
      vecs.push_back('{1, 0, 0, 0,  0, 2,  0, 0,  0, 0});
      vecs.push_back('{0, 1, 1, 0,  0, 40, 0, 10, 9, 10});
      vecs.push_back('{0, 1, 0, 0,  0, 12, 7, 7,  6, 7});
      vecs.push_back('{0, 1, 0, 0,  0, 2,  7, 7,  6, 7});
      vecs.push_back('{0, 0, 0, 0,  0, 10, 7, 7,  6, 7});
      vecs.push_back('{0, 1, 1, 0,  0, 2,  8, 8,  7, 8});
      vecs.push_back('{0, 1, 1, 0,  0, 3,  8, 8,  7, 8});
      vecs.push_back('{0, 1, 1, 1,  7, 1,  7, 7,  7, 7});
      vecs.push_back('{0, 1, 1, 1, 13, 1,  9, 13, 9, 13});
      vecs.push_back('{0, 1, 1, 1,  5, 1,  5, 5,  5, 5});
      vecs.push_back('{0, 1, 1, 0,  0, 1,  5, 5,  5, 5});
      vecs.push_back('{1, 1, 1, 0,  0, 1,  0, 0,  0, 0});
      vecs.push_back('{0, 1, 1, 0,  0, 3,  0, 0,  0, 0});
      vecs.push_back('{0, 1, 1, 0,  0, 1,  1, 1,  1, 1});
      vecs.push_back('{0, 1, 0, 1, 15, 1,  9, 15, 9, 15});
      vecs.push_back('{0, 1, 1, 0,  0, 4,  0, 0,  9, 15});
      vecs.push_back('{0, 1, 0, 1,  0, 1,  0, 0,  0, 0});
      vecs.push_back('{0, 1, 0, 0,  0, 8,  8, 14, 0, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            run_cycle(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].d);
         end
         checks++;
         if (int'(count_a) != (SAT ? vecs[i].sa : vecs[i].ea) ||
             int'(count_b) != (SAT ? vecs[i].sb : vecs[i].eb)) begin
            errors++;
            $display("FAIL vec%0d_end got a=%0d b=%0d want a=%0d b=%0d", i,
                     count_a, count_b, SAT ? vecs[i].sa : vecs[i].ea,
                     SAT ? vecs[i].sb : vecs[i].eb);
         end
      end

      // Hand sequence: steady upward run long enough to wrap the 16-state counter.
      run_cycle(1, 0, 1, 0, 0);
      for (int k = 0; k < 70; k++) run_cycle(0, 1, 1, 0, 0);
      // Random tail for broader scoreboard coverage.
      for (int k = 0; k < 200; k++) begin
         run_cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                   int'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_updown_counter_gen
